// File: rtl/psram_spi_pkg.sv
// rtl/psram_spi_pkg.sv - shared opcodes, serial address width and responder state encoding
package psram_spi_pkg;

  localparam logic [7:0] PSRAM_CMD_READ   = 8'hD0;
  localparam logic [7:0] PSRAM_CMD_WRITE  = 8'h40;
  localparam int         PSRAM_ADDR_WIDTH = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_TURN,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } psram_resp_state_e;

endpackage

// File: rtl/psram_spi_responder_if.sv
// rtl/psram_spi_responder_if.sv - serial link between psram controller (master) and responder (slave)
interface psram_spi_responder_if;
  logic ce_n;
  logic mosi;
  logic miso;

  modport master (output ce_n, output mosi, input miso);
  modport slave  (input ce_n, input mosi, output miso);
endinterface

// File: rtl/psram_resp_mem.sv
// rtl/psram_resp_mem.sv - byte-wide true dual-port RAM, 1-cycle read; port A = SPI, port B = backdoor
module psram_resp_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [7:0]    wdata_a,
  output logic [7:0]    rdata_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [7:0]    wdata_b,
  output logic [7:0]    rdata_b
);

  logic [7:0] mem [2**AW];

  // Port A is written last so the SPI side wins a same-address collision.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= wdata_b;
    if (we_a) mem[addr_a] <= wdata_a;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_a <= 8'h00;
      rdata_b <= 8'h00;
    end else begin
      rdata_a <= mem[addr_a];
      rdata_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/psram_spi_responder.sv
// rtl/psram_spi_responder.sv - SPI PSRAM responder; PSRAM_RESP_FAST_READ_WAIT_EN adds read dummy cycles
module psram_spi_responder
  import psram_spi_pkg::*;
#(
  parameter logic [7:0] CMD_READ       = PSRAM_CMD_READ,
  parameter logic [7:0] CMD_WRITE      = PSRAM_CMD_WRITE,
  parameter int         ADDR_WIDTH     = PSRAM_ADDR_WIDTH,
  parameter int         MEM_ADDR_WIDTH = 12,
  parameter int         WAIT_CYCLES    = 4
) (
  input  logic                      clk,
  input  logic                      resetn,
  psram_spi_responder_if.slave      spi,
  output logic                      busy,
  output logic                      cmd_err,
  output logic [15:0]               wr_byte_count,
  input  logic                      bd_we,
  input  logic [MEM_ADDR_WIDTH-1:0] bd_addr,
  input  logic [7:0]                bd_wdata,
  output logic [7:0]                bd_rdata
);

  // One counter serves opcode, address, wait and data phases.
  localparam int CNT_MAX = (ADDR_WIDTH > WAIT_CYCLES) ? ((ADDR_WIDTH > 8) ? ADDR_WIDTH : 8)
                                                      : ((WAIT_CYCLES > 8) ? WAIT_CYCLES : 8);
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int SH_W    = (MEM_ADDR_WIDTH - 1 > 8) ? MEM_ADDR_WIDTH - 1 : 8;

  psram_resp_state_e         state_q, state_d;
  logic [CNT_W-1:0]          cnt;
  logic [SH_W-1:0]           sh;
  logic [MEM_ADDR_WIDTH-1:0] addr, wr_addr, ram_addr;
  logic [7:0]                wr_data, op, ram_rdata;
  logic                      wr_en, is_rd, bad_op, miso_q;

  assign op       = {sh[6:0], spi.mosi};
  assign bad_op   = !spi.ce_n && state_q == ST_CMD && cnt == CNT_W'(7)
                    && op != CMD_READ && op != CMD_WRITE;
  assign busy     = state_q != ST_IDLE;
  assign spi.miso = miso_q;
  assign ram_addr = wr_en ? wr_addr : addr;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (spi.ce_n) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_CMD;
        ST_CMD: if (cnt == CNT_W'(7))
          state_d = (op == CMD_READ || op == CMD_WRITE) ? ST_ADDR : ST_IGNORE;
        ST_ADDR: if (cnt == CNT_W'(ADDR_WIDTH - 1))
          state_d = is_rd ? ST_TURN : ST_WDATA;
`ifdef PSRAM_RESP_FAST_READ_WAIT_EN
        ST_TURN: state_d = ST_WAIT;
        ST_WAIT: if (cnt == CNT_W'(WAIT_CYCLES - 1)) state_d = ST_RDATA;
`else
        ST_TURN: state_d = ST_RDATA;
`endif
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt           <= '0;
      sh            <= '0;
      addr          <= '0;
      wr_addr       <= '0;
      wr_data       <= 8'h00;
      wr_en         <= 1'b0;
      is_rd         <= 1'b0;
      miso_q        <= 1'b0;
      cmd_err       <= 1'b0;
      wr_byte_count <= 16'h0000;
    end else begin
      cmd_err <= bad_op;
      wr_en   <= 1'b0;
      miso_q  <= 1'b0;
      if (wr_en && wr_byte_count != 16'hFFFF) wr_byte_count <= wr_byte_count + 16'd1;

      // The IDLE cycle already samples opcode bit 7, so CMD starts at bit 1.
      if (state_q == ST_IDLE)       cnt <= CNT_W'(1);
      else if (state_d != state_q)  cnt <= '0;
      else                          cnt <= cnt + CNT_W'(1);

      if (!spi.ce_n) begin
        case (state_q)
          ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA: begin
            sh <= {sh[SH_W-2:0], spi.mosi};
            if (state_q == ST_CMD && cnt == CNT_W'(7)) is_rd <= (op == CMD_READ);
            if (state_q == ST_ADDR && cnt == CNT_W'(ADDR_WIDTH - 1))
              addr <= {sh[MEM_ADDR_WIDTH-2:0], spi.mosi};
            if (state_q == ST_WDATA && cnt[2:0] == 3'd7) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= op;
              addr    <= addr + 1'b1;
            end
          end
          // Byte boundary takes the RAM word and moves the read address on to prefetch the next.
          ST_RDATA: begin
            if (cnt[2:0] == 3'd0) begin
              miso_q <= ram_rdata[7];
              sh     <= SH_W'({ram_rdata[6:0], 1'b0});
              addr   <= addr + 1'b1;
            end else begin
              miso_q <= sh[7];
              sh     <= {sh[SH_W-2:0], 1'b0};
            end
          end
          default: ;
        endcase
      end
    end
  end

  psram_resp_mem #(.AW(MEM_ADDR_WIDTH)) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .we_a    (wr_en & resetn),
    .addr_a  (ram_addr),
    .wdata_a (wr_data),
    .rdata_a (ram_rdata),
    .we_b    (bd_we),
    .addr_b  (bd_addr),
    .wdata_b (bd_wdata),
    .rdata_b (bd_rdata)
  );

endmodule

// File: tb/tb_psram_spi_responder.sv
// tb/tb_psram_spi_responder.sv - directed self-checking bench for psram_spi_responder
module tb_psram_spi_responder;

`ifdef PSRAM_RESP_FAST_READ_WAIT_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        busy, cmd_err;
  logic [15:0] wr_byte_count;
  logic        bd_we;
  logic [11:0] bd_addr;
  logic [7:0]  bd_wdata, bd_rdata;
  int          tests = 0;
  int          fails = 0;

  psram_spi_responder_if spi_if ();

  psram_spi_responder dut (
    .clk           (clk),
    .resetn        (resetn),
    .spi           (spi_if.slave),
    .busy          (busy),
    .cmd_err       (cmd_err),
    .wr_byte_count (wr_byte_count),
    .bd_we         (bd_we),
    .bd_addr       (bd_addr),
    .bd_wdata      (bd_wdata),
    .bd_rdata      (bd_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      spi_if.ce_n = 1'b0;
      spi_if.mosi = v[i];
      tick();
    end
  endtask

  task automatic end_frame();
    spi_if.ce_n = 1'b1;
    spi_if.mosi = 1'b0;
    tick();
  endtask

  task automatic bd_write(input logic [11:0] a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a; bd_wdata = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic bd_check(input string tag, input logic [11:0] a, input logic [7:0] exp);
    bd_addr = a;
    tick();
    check(tag, {24'h0, bd_rdata}, {24'h0, exp});
  endtask

  logic [31:0] rd_word;
  logic        first_bit;

  initial begin
    resetn = 1'b0; spi_if.ce_n = 1'b1; spi_if.mosi = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    tick(); tick();
    check("rst_miso", {31'h0, spi_if.miso}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_cmd_err", {31'h0, cmd_err}, 32'h0);
    check("rst_wr_cnt", {16'h0, wr_byte_count}, 32'h0);
    check("rst_bd_rdata", {24'h0, bd_rdata}, 32'h0);
    resetn = 1'b1;
    tick();

    // read of four preloaded bytes
    bd_write(12'h010, 8'hA5); bd_write(12'h011, 8'h5A);
    bd_write(12'h012, 8'hC3); bd_write(12'h013, 8'h3C);
    send_bits(32'hD0, 8);
    check("rd_busy", {31'h0, busy}, 32'h1);
    send_bits(32'h000010, 24);
    check("rd_turn_miso", {31'h0, spi_if.miso}, 32'h0);
    spi_if.mosi = 1'b0;
    for (int k = 0; k < LAT - 1; k++) begin
      tick();
      check("rd_pre_miso", {31'h0, spi_if.miso}, 32'h0);
    end
    rd_word = '0;
    for (int i = 0; i < 32; i++) begin
      tick();
      if (i == 0) first_bit = spi_if.miso;
      rd_word = {rd_word[30:0], spi_if.miso};
    end
    check("rd_first_bit", {31'h0, first_bit}, 32'h1);
    check("rd_data", rd_word, 32'hA55AC33C);
    end_frame();
    check("rd_end_busy", {31'h0, busy}, 32'h0);
    check("rd_end_miso", {31'h0, spi_if.miso}, 32'h0);

    // two-byte write
    send_bits(32'h40, 8); send_bits(32'h000100, 24);
    send_bits(32'h11, 8); send_bits(32'h22, 8);
    end_frame();
    check("wr_count2", {16'h0, wr_byte_count}, 32'd2);
    bd_check("wr_0x100", 12'h100, 8'h11);
    bd_check("wr_0x101", 12'h101, 8'h22);

    // write wrapping past the top of RAM
    send_bits(32'h40, 8); send_bits(32'h000FFF, 24);
    send_bits(32'h77, 8); send_bits(32'h88, 8);
    end_frame();
    bd_check("wrap_0xfff", 12'hFFF, 8'h77);
    bd_check("wrap_0x000", 12'h000, 8'h88);
    check("wrap_count4", {16'h0, wr_byte_count}, 32'd4);

    // unknown opcode
    send_bits(32'h9F, 8);
    check("bad_cmd_err", {31'h0, cmd_err}, 32'h1);
    send_bits(32'h1, 1);
    check("bad_cmd_err_pulse", {31'h0, cmd_err}, 32'h0);
    check("bad_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      send_bits(32'h1, 1);
      check("bad_miso", {31'h0, spi_if.miso}, 32'h0);
    end
    end_frame();
    check("bad_end_busy", {31'h0, busy}, 32'h0);
    bd_check("bad_ram_unchanged", 12'h010, 8'hA5);
    check("bad_count", {16'h0, wr_byte_count}, 32'd4);

    // truncated write: one full byte then 4 bits
    bd_write(12'h021, 8'hEE);
    send_bits(32'h40, 8); send_bits(32'h000020, 24);
    send_bits(32'h99, 8); send_bits(32'hF, 4);
    end_frame();
    check("part_busy", {31'h0, busy}, 32'h0);
    check("part_count", {16'h0, wr_byte_count}, 32'd5);
    bd_check("part_0x20", 12'h020, 8'h99);
    bd_check("part_0x21", 12'h021, 8'hEE);

    // reset during a write byte
    bd_write(12'h030, 8'h66);
    send_bits(32'h40, 8); send_bits(32'h000030, 24); send_bits(32'h5, 4);
    resetn = 1'b0;
    tick();
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    check("rst_mid_count", {16'h0, wr_byte_count}, 32'd0);
    resetn = 1'b1;
    spi_if.ce_n = 1'b1;
    tick();
    bd_check("rst_mid_ram", 12'h030, 8'h66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
